// File: rtl/ppi_phase_sched.sv
// ppi_phase_sched: polyphase interpolator phase scheduler (accept, load strobe, commutator sequencing).
// Optional underrun counter enabled by defining PPI_UNDERRUN_CNT_EN.
module ppi_phase_sched #(
    parameter int gp_interp_factor = 4,
    parameter int gp_phase_width   = 2,
    parameter int gp_cnt_width     = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst_ah,
    input  logic                      i_ena,
    input  logic                      i_valid,
    output logic                      o_ready,
    output logic                      o_load,
    output logic                      o_valid,
    output logic [gp_phase_width-1:0] o_phase,
    output logic                      o_last,
`ifdef PPI_UNDERRUN_CNT_EN
    input  logic                      i_cnt_clr,
    output logic [gp_cnt_width-1:0]   o_underrun_cnt,
`endif
    input  logic                      i_out_ready
);
    typedef enum logic {IDLE, RUN} state_t;
    localparam logic [gp_phase_width-1:0] LAST = gp_phase_width'(gp_interp_factor - 1);
    state_t                    state_q, state_d;
    logic [gp_phase_width-1:0] phase_q, phase_d;
    logic                      is_last, grant, underrun;
    assign o_valid = state_q == RUN;
    assign o_phase = phase_q;
    assign is_last = phase_q == LAST;
    assign o_last  = o_valid & is_last;
    assign grant   = i_ena & o_valid & i_out_ready;
    // A sample is only taken when idle or as the final phase is granted, so no input buffer is needed.
    assign o_ready = ~i_rst_ah & i_ena & (~o_valid | (is_last & i_out_ready));
    assign o_load  = i_valid & o_ready;
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        underrun = 1'b0;
        if (state_q == IDLE) begin
            state_d = o_load ? RUN : IDLE;
            phase_d = '0;
        end else if (grant) begin
            phase_d  = is_last ? '0 : phase_q + gp_phase_width'(1);
            state_d  = (is_last & ~o_load) ? IDLE : RUN;
            underrun = is_last & ~o_load;
        end
    end
    always_ff @(posedge i_clk or posedge i_rst_ah) begin
        if (i_rst_ah) begin
            state_q <= IDLE;
            phase_q <= '0;
        end else if (i_ena) begin
            state_q <= state_d;
            phase_q <= phase_d;
        end
    end
`ifdef PPI_UNDERRUN_CNT_EN
    logic [gp_cnt_width-1:0] cnt_q, cnt_d;
    assign cnt_d          = i_cnt_clr ? '0 : cnt_q + gp_cnt_width'(underrun & ~&cnt_q);
    assign o_underrun_cnt = cnt_q;
    always_ff @(posedge i_clk or posedge i_rst_ah) begin
        if (i_rst_ah) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
`endif
endmodule

// File: tb/tb_ppi_phase_sched.sv
// tb_ppi_phase_sched: vector table, hand sequences and randomized run against a reference model.
// Counter checks are compiled in when PPI_UNDERRUN_CNT_EN is defined.
module tb_ppi_phase_sched;
    localparam int L = 4;
    localparam int CMAX = 3;
    logic clk = 1'b0, rst = 1'b1, ena = 1'b0, valid = 1'b0, ordy = 1'b0, clr = 1'b0;
    logic rdy, ld, vld, lst;
    logic [1:0] ph;
    logic [1:0] cnt;
    int checks = 0, errors = 0;
    bit m_run = 1'b0;
    int m_ph = 0, m_cnt = 0;

    ppi_phase_sched #(.gp_interp_factor(L), .gp_phase_width(2), .gp_cnt_width(2)) dut (
        .i_clk(clk), .i_rst_ah(rst), .i_ena(ena), .i_valid(valid), .o_ready(rdy), .o_load(ld),
        .o_valid(vld), .o_phase(ph), .o_last(lst),
`ifdef PPI_UNDERRUN_CNT_EN
        .i_cnt_clr(clr), .o_underrun_cnt(cnt),
`endif
        .i_out_ready(ordy)
    );
`ifndef PPI_UNDERRUN_CNT_EN
    assign cnt = 2'd0;
`endif

    always #5 clk = ~clk;

    typedef struct {
        bit e, v, r;
        bit x_rdy, x_ld, x_vld;
        int x_ph;
        bit x_lst;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Entered and left at a negedge: drive, compare against the model, then advance the model across the edge.
    task automatic cyc(input bit e, input bit v, input bit r, input bit c, input string tag);
        bit e_rdy, e_ld, under;
        ena = e; valid = v; ordy = r; clr = c;
        #1;
        e_rdy = e & (!m_run || (m_ph == L - 1 && r));
        e_ld  = v & e_rdy;
        chk({tag, ".ready"}, int'(rdy), int'(e_rdy));
        chk({tag, ".load"}, int'(ld), int'(e_ld));
        chk({tag, ".valid"}, int'(vld), int'(m_run));
        chk({tag, ".phase"}, int'(ph), m_run ? m_ph : 0);
        chk({tag, ".last"}, int'(lst), int'(m_run && m_ph == L - 1));
`ifdef PPI_UNDERRUN_CNT_EN
        chk({tag, ".cnt"}, int'(cnt), m_cnt);
`endif
        under = 1'b0;
        if (e) begin
            if (m_run && r) begin
                if (m_ph < L - 1) m_ph++;
                else if (e_ld) m_ph = 0;
                else begin m_run = 1'b0; m_ph = 0; under = 1'b1; end
            end else if (!m_run && e_ld) begin
                m_run = 1'b1; m_ph = 0;
            end
        end
        if (c) m_cnt = 0;
        else if (under && m_cnt < CMAX) m_cnt++;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // cycles 0-5: single pulse; 6-11: backpressure at phase 1; 12-14: enable low at phase 2; 15-20: back-to-back
        tbl = '{
            '{1,1,1, 1,1,0,0,0}, '{1,0,1, 0,0,1,0,0}, '{1,0,1, 0,0,1,1,0}, '{1,0,1, 0,0,1,2,0},
            '{1,0,1, 1,0,1,3,1}, '{1,0,1, 1,0,0,0,0},
            '{1,1,1, 1,1,0,0,0}, '{1,0,1, 0,0,1,0,0}, '{1,0,0, 0,0,1,1,0}, '{1,0,0, 0,0,1,1,0},
            '{1,0,0, 0,0,1,1,0}, '{1,0,1, 0,0,1,1,0},
            '{0,1,1, 0,0,1,2,0}, '{0,1,1, 0,0,1,2,0}, '{1,0,1, 0,0,1,2,0},
            '{1,1,1, 1,1,1,3,1}, '{1,1,1, 0,0,1,0,0}, '{1,1,1, 0,0,1,1,0}, '{1,1,1, 0,0,1,2,0},
            '{1,1,1, 1,1,1,3,1}, '{1,0,1, 0,0,1,0,0}
        };
        #1;
        chk("rst.valid", int'(vld), 0);
        chk("rst.phase", int'(ph), 0);
        chk("rst.ready", int'(rdy), 0);
        chk("rst.last", int'(lst), 0);
        ena = 1'b1; valid = 1'b1; ordy = 1'b1;
        #1;
        chk("rst.ready_held", int'(rdy), 0);
        chk("rst.load_held", int'(ld), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < tbl.size(); i++) begin
            ena = tbl[i].e; valid = tbl[i].v; ordy = tbl[i].r; clr = 1'b0;
            #1;
            chk($sformatf("tbl%0d.ready", i), int'(rdy), int'(tbl[i].x_rdy));
            chk($sformatf("tbl%0d.load", i), int'(ld), int'(tbl[i].x_ld));
            chk($sformatf("tbl%0d.valid", i), int'(vld), int'(tbl[i].x_vld));
            chk($sformatf("tbl%0d.phase", i), int'(ph), tbl[i].x_ph);
            chk($sformatf("tbl%0d.last", i), int'(lst), int'(tbl[i].x_lst));
            @(negedge clk);
        end
        m_run = 1'b1; m_ph = 1;
        m_cnt = 0;
`ifdef PPI_UNDERRUN_CNT_EN
        m_cnt = int'(cnt);
`endif
        cyc(1, 0, 1, 0, "pre_rst");
        chk("pre_rst.phase2", int'(ph), 2);
        #2 rst = 1'b1;
        #1;
        chk("async.valid", int'(vld), 0);
        chk("async.phase", int'(ph), 0);
        chk("async.ready", int'(rdy), 0);
        chk("async.load", int'(ld), 0);
        chk("async.last", int'(lst), 0);
        @(negedge clk);
        rst = 1'b0;
        m_run = 1'b0; m_ph = 0; m_cnt = 0;
        cyc(1, 1, 1, 0, "post_rst.acc");
        chk("post_rst.phase0", int'(ph), 0);
        chk("post_rst.valid", int'(vld), 1);
`ifdef PPI_UNDERRUN_CNT_EN
        cyc(1, 0, 1, 1, "cnt.clr0");
        for (int s = 0; s < 5; s++) begin
            cyc(1, 1, 1, 0, "cnt.acc");
            for (int p = 0; p < L; p++) cyc(1, 0, 1, 0, "cnt.ph");
            chk($sformatf("cnt.sample%0d", s), int'(cnt), (s + 1 > CMAX) ? CMAX : s + 1);
            cyc(1, 0, 1, 0, "cnt.gap");
        end
        cyc(0, 0, 1, 1, "cnt.clr");
        chk("cnt.cleared", int'(cnt), 0);
`endif
        for (int i = 0; i < 600; i++)
            cyc($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 40) == 0, "rnd");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
